// File: rtl/pooling_window_buffer_if.sv
// Pixel-in / window-out bundle between a pixel source and pooling_window_buffer.
// The master drives pixels; the slave (the window buffer) drives assembled windows.
interface pooling_window_buffer_if #(
  parameter int D_WIDTH   = 8,
  parameter int POOL_SIZE = 2
) ();
  logic                                   in_valid;
  logic [D_WIDTH-1:0]                     in_data;
  logic                                   out_valid;
  logic [D_WIDTH*POOL_SIZE*POOL_SIZE-1:0] out_data;
  logic                                   out_last;

  modport master (output in_valid, in_data, input out_valid, out_data, out_last);
  modport slave  (input in_valid, in_data, output out_valid, out_data, out_last);
endinterface

// File: rtl/pooling_window_buffer.sv
// Raster-order pixel stream to non-overlapping POOL_SIZE x POOL_SIZE window former.
// Earlier rows of a window band live in a line buffer; the final row is staged and completed by in_data.
module pooling_window_buffer #(
  parameter int D_WIDTH    = 8,
  parameter int POOL_SIZE  = 2,
  parameter int IMG_WIDTH  = 8,
  parameter int IMG_HEIGHT = 8
) (
  input logic                    clk,
  input logic                    rst_n,
  pooling_window_buffer_if.slave bus
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam int PW = $clog2(POOL_SIZE);
  localparam int WW = D_WIDTH * POOL_SIZE * POOL_SIZE;

  if (POOL_SIZE < 2 || (IMG_WIDTH % POOL_SIZE) != 0 || (IMG_HEIGHT % POOL_SIZE) != 0) begin : g_bad_params
    $error("pooling_window_buffer: illegal POOL_SIZE / IMG_WIDTH / IMG_HEIGHT combination");
  end

  logic [CW-1:0]      r_col;
  logic [RW-1:0]      r_row;
  logic [PW-1:0]      r_cph;
  logic [PW-1:0]      r_rph;
  logic [D_WIDTH-1:0] r_line  [POOL_SIZE-1][IMG_WIDTH];
  logic [D_WIDTH-1:0] r_stage [POOL_SIZE-1];
  logic               r_out_valid;
  logic               r_out_last;
  logic [WW-1:0]      r_out_data;

  logic [CW-1:0]      w_base;
  logic [WW-1:0]      w_win;
  logic               w_col_end;
  logic               w_row_end;
  logic               w_complete;
  logic               w_frame_end;

  assign w_col_end   = (r_col == CW'(IMG_WIDTH - 1));
  assign w_row_end   = (r_row == RW'(IMG_HEIGHT - 1));
  assign w_complete  = bus.in_valid && (r_rph == PW'(POOL_SIZE - 1)) && (r_cph == PW'(POOL_SIZE - 1));
  assign w_frame_end = w_col_end && w_row_end;

  // Phase counters run alongside col/row so no modulo is needed; both wrap
  // together with col/row because the image dimensions are multiples of POOL_SIZE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col       <= '0;
      r_row       <= '0;
      r_cph       <= '0;
      r_rph       <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      if (bus.in_valid) begin
        r_cph <= (r_cph == PW'(POOL_SIZE - 1)) ? '0 : r_cph + 1'b1;
        if (w_col_end) begin
          r_col <= '0;
          r_row <= w_row_end ? '0 : r_row + 1'b1;
          r_rph <= (r_rph == PW'(POOL_SIZE - 1)) ? '0 : r_rph + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
        if (w_complete) begin
          r_out_valid <= 1'b1;
          r_out_last  <= w_frame_end;
          r_out_data  <= w_win;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (bus.in_valid) begin
      if (r_rph != PW'(POOL_SIZE - 1)) begin
        r_line[r_rph][r_col] <= bus.in_data;
      end else if (r_cph != PW'(POOL_SIZE - 1)) begin
        r_stage[r_cph] <= bus.in_data;
      end
    end
  end

  always_comb begin
    w_win  = '0;
    w_base = r_col - CW'(POOL_SIZE - 1);
    for (int unsigned dr = 0; dr < POOL_SIZE - 1; dr++) begin
      for (int unsigned dc = 0; dc < POOL_SIZE; dc++) begin
        w_win[D_WIDTH*(dr*POOL_SIZE+dc) +: D_WIDTH] = r_line[dr][w_base + CW'(dc)];
      end
    end
    for (int unsigned dc = 0; dc < POOL_SIZE - 1; dc++) begin
      w_win[D_WIDTH*((POOL_SIZE-1)*POOL_SIZE+dc) +: D_WIDTH] = r_stage[dc];
    end
    w_win[WW-1 -: D_WIDTH] = bus.in_data;
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_last  = r_out_last;
  assign bus.out_data  = r_out_data;
endmodule

// File: tb/tb_pooling_window_buffer.sv
// Scoreboard bench for pooling_window_buffer: a 4x4 instance for the main scenarios
// and a default-parameter 8x8 instance for the full-scale frame.
module tb_pooling_window_buffer;
  localparam int DW = 8;
  localparam int PS = 2;
  localparam int IW = 4;
  localparam int IH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pooling_window_buffer_if #(.D_WIDTH(DW), .POOL_SIZE(PS)) sbus ();
  pooling_window_buffer_if #(.D_WIDTH(8),  .POOL_SIZE(2))  bbus ();

  pooling_window_buffer #(.D_WIDTH(DW), .POOL_SIZE(PS), .IMG_WIDTH(IW), .IMG_HEIGHT(IH)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sbus)
  );

  pooling_window_buffer u_big (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bbus)
  );

  typedef struct { logic [31:0] data; logic last; int cyc; } exp_t;
  typedef struct { logic [31:0] data; logic last; } obs_t;

  exp_t sq[$];
  exp_t bq[$];
  obs_t slog[$];

  int total = 0;
  int passed = 0;
  int cyc = 0;
  int tcol = 0, trow = 0;
  int bcol = 0, brow = 0;
  int bcount = 0;
  logic s_prev = 1'b0;
  logic b_prev = 1'b0;
  logic [7:0] fb [IH][IW];
  logic [31:0] frame_exp [4] = '{32'h05040100, 32'h07060302, 32'h0D0C0908, 32'h0F0E0B0A};

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard for the 4x4 instance
  always @(negedge clk) begin
    exp_t e;
    obs_t o;
    if (sbus.out_valid) begin
      total++;
      if (s_prev !== 1'b0) $display("FAIL s_consecutive: out_valid high two cycles running at cycle %0d", cyc);
      else passed++;
      total++;
      if (sq.size() == 0) begin
        $display("FAIL s_unexpected: window %h with nothing expected", sbus.out_data);
      end else begin
        passed++;
        e = sq.pop_front();
        total++;
        if (sbus.out_data !== e.data) $display("FAIL s_data: got %h expected %h", sbus.out_data, e.data);
        else passed++;
        total++;
        if (sbus.out_last !== e.last) $display("FAIL s_last: got %b expected %b (window %h)", sbus.out_last, e.last, e.data);
        else passed++;
        total++;
        if (cyc !== e.cyc) $display("FAIL s_latency: pulse at cycle %0d expected %0d", cyc, e.cyc);
        else passed++;
      end
      o.data = sbus.out_data;
      o.last = sbus.out_last;
      slog.push_back(o);
    end
    s_prev = sbus.out_valid;
  end

  // Scoreboard for the 8x8 instance, followed by a SIZE=4 max comparator model
  always @(negedge clk) begin
    exp_t e;
    logic [7:0] mx;
    if (bbus.out_valid) begin
      bcount++;
      total++;
      if (b_prev !== 1'b0) $display("FAIL b_consecutive: out_valid high two cycles running at cycle %0d", cyc);
      else passed++;
      total++;
      if (bq.size() == 0) begin
        $display("FAIL b_unexpected: window %h with nothing expected", bbus.out_data);
      end else begin
        passed++;
        e = bq.pop_front();
        total++;
        if (bbus.out_data !== e.data) $display("FAIL b_data: got %h expected %h", bbus.out_data, e.data);
        else passed++;
        total++;
        if (bbus.out_last !== e.last) $display("FAIL b_last: got %b expected %b (window %0d)", bbus.out_last, e.last, bcount);
        else passed++;
        total++;
        if (cyc !== e.cyc) $display("FAIL b_latency: pulse at cycle %0d expected %0d", cyc, e.cyc);
        else passed++;
      end
      mx = 8'h00;
      for (int k = 0; k < 4; k++) if (bbus.out_data[8*k +: 8] > mx) mx = bbus.out_data[8*k +: 8];
      total++;
      if (mx !== 8'hFF) $display("FAIL b_pool_max: got %h expected ff", mx);
      else passed++;
    end
    b_prev = bbus.out_valid;
  end

  task automatic send_s(input logic [7:0] v);
    exp_t e;
    logic emit;
    sbus.in_valid = 1'b1;
    sbus.in_data  = v;
    fb[trow][tcol] = v;
    emit = (trow % 2 == 1) && (tcol % 2 == 1);
    if (emit) begin
      e.data = {v, fb[trow][tcol-1], fb[trow-1][tcol], fb[trow-1][tcol-1]};
      e.last = (trow == IH - 1) && (tcol == IW - 1);
    end
    @(posedge clk); #1;
    sbus.in_valid = 1'b0;
    if (emit) begin
      e.cyc = cyc;
      sq.push_back(e);
    end
    if (tcol == IW - 1) begin
      tcol = 0;
      trow = (trow == IH - 1) ? 0 : trow + 1;
    end else begin
      tcol++;
    end
  endtask

  task automatic send_b(input logic [7:0] v);
    exp_t e;
    logic emit;
    bbus.in_valid = 1'b1;
    bbus.in_data  = v;
    emit = (brow % 2 == 1) && (bcol % 2 == 1);
    e.data = {v, v, v, v};
    e.last = (brow == 7) && (bcol == 7);
    @(posedge clk); #1;
    bbus.in_valid = 1'b0;
    if (emit) begin
      e.cyc = cyc;
      bq.push_back(e);
    end
    if (bcol == 7) begin
      bcol = 0;
      brow = (brow == 7) ? 0 : brow + 1;
    end else begin
      bcol++;
    end
  endtask

  task automatic drain(input string name);
    repeat (4) @(negedge clk);
    #1;
    total++;
    if (sq.size() != 0 || bq.size() != 0)
      $display("FAIL %s_drain: %0d/%0d windows still pending, required 0", name, sq.size(), bq.size());
    else passed++;
  endtask

  task automatic check_frame(input string name, input int base);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (base + i >= slog.size()) begin
        $display("FAIL %s_win%0d: missing, required %h", name, i, frame_exp[i]);
      end else if (slog[base+i].data !== frame_exp[i] || slog[base+i].last !== (i == 3)) begin
        $display("FAIL %s_win%0d: got %h last %b, required %h last %b", name, i,
                 slog[base+i].data, slog[base+i].last, frame_exp[i], (i == 3));
      end else passed++;
    end
  endtask

  task automatic test_reset();
    sbus.in_valid = 1'b0; sbus.in_data = '0;
    bbus.in_valid = 1'b0; bbus.in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (sbus.out_valid !== 1'b0 || sbus.out_last !== 1'b0 || sbus.out_data !== 32'h0)
      $display("FAIL reset_small: got valid %b last %b data %h, required 0 0 00000000", sbus.out_valid, sbus.out_last, sbus.out_data);
    else passed++;
    total++;
    if (bbus.out_valid !== 1'b0 || bbus.out_last !== 1'b0 || bbus.out_data !== 32'h0)
      $display("FAIL reset_big: got valid %b last %b data %h, required 0 0 00000000", bbus.out_valid, bbus.out_last, bbus.out_data);
    else passed++;
    rst_n = 1'b1;
  endtask

  task automatic test_full_frame();
    slog.delete();
    for (int v = 0; v < 16; v++) send_s(8'(v));
    drain("full");
    total++;
    if (slog.size() != 4) $display("FAIL full_count: got %0d windows, required 4", slog.size());
    else passed++;
    check_frame("full", 0);
  endtask

  task automatic test_gapped();
    slog.delete();
    for (int v = 0; v < 16; v++) begin
      send_s(8'(v));
      repeat (3) @(posedge clk);
      #1;
    end
    drain("gap");
    total++;
    if (slog.size() != 4) $display("FAIL gap_count: got %0d windows, required 4", slog.size());
    else passed++;
    check_frame("gap", 0);
  endtask

  task automatic test_back_to_back();
    slog.delete();
    for (int v = 0; v < 16; v++) send_s(8'(v));
    for (int v = 0; v < 16; v++) send_s(8'(8'hF0 + v));
    drain("b2b");
    total++;
    if (slog.size() != 8) $display("FAIL b2b_count: got %0d windows, required 8", slog.size());
    else passed++;
    check_frame("b2b_a", 0);
    total++;
    if (slog.size() < 8 || slog[4].data !== 32'hF5F4F1F0)
      $display("FAIL b2b_first_b: got %h, required f5f4f1f0", (slog.size() > 4) ? slog[4].data : 32'hx);
    else passed++;
    total++;
    if (slog.size() < 8 || slog[7].data !== 32'hFFFEFBFA || slog[7].last !== 1'b1 || slog[4].last !== 1'b0)
      $display("FAIL b2b_last_b: got %h last %b, required fffefbfa last 1", (slog.size() > 7) ? slog[7].data : 32'hx,
               (slog.size() > 7) ? slog[7].last : 1'bx);
    else passed++;
  endtask

  task automatic test_reset_mid_frame();
    slog.delete();
    for (int v = 0; v <= 9; v++) send_s(8'(v));
    rst_n = 1'b0;
    #1;
    total++;
    if (sbus.out_valid !== 1'b0 || sbus.out_data !== 32'h0)
      $display("FAIL midrst_async: got valid %b data %h, required 0 00000000", sbus.out_valid, sbus.out_data);
    else passed++;
    sq.delete();
    tcol = 0;
    trow = 0;
    repeat (2) @(negedge clk);
    total++;
    if (sbus.out_valid !== 1'b0 || sbus.out_data !== 32'h0)
      $display("FAIL midrst_hold: got valid %b data %h, required 0 00000000", sbus.out_valid, sbus.out_data);
    else passed++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    slog.delete();
    for (int v = 0; v < 16; v++) send_s(8'(8'h20 + v));
    drain("midrst");
    total++;
    if (slog.size() != 4 || slog[0].data !== 32'h25242120)
      $display("FAIL midrst_first: got %0d windows first %h, required 4 first 25242120", slog.size(),
               (slog.size() > 0) ? slog[0].data : 32'hx);
    else passed++;
    total++;
    if (slog.size() != 4 || slog[3].data !== 32'h2F2E2B2A || slog[3].last !== 1'b1)
      $display("FAIL midrst_final: got %h, required 2f2e2b2a with last", (slog.size() > 3) ? slog[3].data : 32'hx);
    else passed++;
  endtask

  task automatic test_full_scale();
    bcount = 0;
    for (int i = 0; i < 64; i++) send_b(8'hFF);
    drain("scale");
    total++;
    if (bcount != 16) $display("FAIL scale_count: got %0d windows, required 16", bcount);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_gapped();
    test_back_to_back();
    test_reset_mid_frame();
    test_full_scale();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
